// File: rtl/layer_id_sorter.sv
// layer_id_sorter: one instance per die in a 3D stack. The die takes its chip ID
// from the layer below, or uses ID 0 if it is the bottom layer. It then offers
// chip_id+1 to the layer above and waits for that layer to answer. When no answer
// arrives it retries, then raises transmit power step by step up to the ceiling.
// If the die is never answered, it declares itself the top of the stack.
module layer_id_sorter #(
    parameter int          ID_W     = 4,
    parameter int          PWR_W    = 4,
    parameter int          PWR_INIT = 1,
    parameter int          TIMEOUT  = 15,
    parameter int          RETRIES  = 2,
    parameter logic [15:0] MAGIC    = 16'hBEAF,
    parameter logic [3:0]  TAG      = 4'hA,
    parameter int          FRAME_W  = 4 + PWR_W + 2 * ID_W + 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               f_layer,
    input  logic               rx_valid,
    input  logic [FRAME_W-1:0] rx_data,
    output logic               tx_valid,
    output logic [FRAME_W-1:0] tx_data,
    output logic [ID_W-1:0]    chip_id,
    output logic [PWR_W-1:0]   power_level,
    output logic               sort_finish,
    output logic               top_detect
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int RTY_W = (RETRIES > 1) ? $clog2(RETRIES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_LAST   = RTY_W'(RETRIES - 1);
    localparam logic [PWR_W-1:0] PWR_MAX_V  = '1;
    localparam logic [PWR_W-1:0] PWR_INIT_V = PWR_W'(PWR_INIT);

    // Field offsets inside a frame, counted from the LSB.
    localparam int NEXT_LSB = 16;
    localparam int MYID_LSB = 16 + ID_W;
    localparam int PWR_LSB  = 16 + 2 * ID_W;
    localparam int TAG_LSB  = PWR_LSB + PWR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_ID,
        S_TX,
        S_WAIT_ACK,
        S_DONE,
        S_TOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [PWR_W-1:0]   pwr_q, pwr_d;
    logic [ID_W-1:0]    chip_id_q, chip_id_d;
    logic               tx_valid_q, tx_valid_d;
    logic [FRAME_W-1:0] tx_data_q, tx_data_d;
    logic               sort_finish_q, sort_finish_d;
    logic               top_detect_q, top_detect_d;

    // Decoded receive frame.
    logic [3:0]       rx_tag;
    logic [15:0]      rx_magic;
    logic [ID_W-1:0]  rx_my_id;
    logic [ID_W-1:0]  rx_next_id;
    logic             frame_ok;
    logic             ack;
    logic [ID_W-1:0]  id_above;
    logic [ID_W-1:0]  tx_next_id;

    // The peer's power field travels in every frame but does not drive any decision here.
    logic             unused_rx_pwr;

    assign rx_tag        = rx_data[TAG_LSB +: 4];
    assign rx_magic      = rx_data[15:0];
    assign rx_my_id      = rx_data[MYID_LSB +: ID_W];
    assign rx_next_id    = rx_data[NEXT_LSB +: ID_W];
    assign unused_rx_pwr = ^rx_data[PWR_LSB +: PWR_W];

    assign frame_ok   = rx_valid && (rx_magic == MAGIC) && (rx_tag == TAG);
    // The layer above answers with the ID this die handed out, which wraps at 2^ID_W.
    assign id_above   = chip_id_q + ID_W'(1);
    assign ack        = frame_ok && (rx_my_id == id_above);
    assign tx_next_id = chip_id_d + ID_W'(1);

    // Next-state logic: discovery, transmission and retry/power escalation, plus registered-output next values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        pwr_d     = pwr_q;
        chip_id_d = chip_id_q;

        case (state_q)
            S_IDLE: begin
                if (f_layer) begin
                    chip_id_d = '0;
                    state_d   = S_TX;
                end else begin
                    state_d = S_RX_ID;
                end
            end
            S_RX_ID: begin
                if (frame_ok) begin
                    chip_id_d = rx_next_id;
                    state_d   = S_TX;
                end
            end
            S_TX: begin
                cnt_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // An ack on the final window cycle still counts; it is checked before the timeout.
                if (ack) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    if (retry_q < RTY_LAST) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_TX;
                    end else if (pwr_q < PWR_MAX_V) begin
                        pwr_d   = pwr_q + 1'b1;
                        retry_d = '0;
                        state_d = S_TX;
                    end else begin
                        state_d = S_TOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_TOP:   state_d = S_TOP;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered. They are computed from the next state so that they line up with it.
        tx_valid_d    = (state_d == S_TX);
        tx_data_d     = tx_data_q;
        if (tx_valid_d) begin
            tx_data_d = {TAG, pwr_d, chip_id_d, tx_next_id, MAGIC};
        end
        sort_finish_d = (state_d == S_DONE) || (state_d == S_TOP);
        top_detect_d  = (state_d == S_TOP);
    end

    // State and output registers; reset takes priority over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            retry_q       <= '0;
            pwr_q         <= PWR_INIT_V;
            chip_id_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            sort_finish_q <= 1'b0;
            top_detect_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pwr_q         <= pwr_d;
            chip_id_q     <= chip_id_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            sort_finish_q <= sort_finish_d;
            top_detect_q  <= top_detect_d;
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign chip_id     = chip_id_q;
    assign power_level = pwr_q;
    assign sort_finish = sort_finish_q;
    assign top_detect  = top_detect_q;

endmodule

// File: tb/tb_layer_id_sorter.sv
// Testbench for layer_id_sorter. It runs directed scenarios and randomized frame
// traffic, and checks every cycle against an attempt-count reference model.
module tb_layer_id_sorter;

    localparam int          PWR_INIT = 1;
    localparam int          TIMEOUT  = 15;
    localparam int          RETRIES  = 2;
    localparam int          PWR_MAX  = 15;
    localparam int          MAX_TX   = RETRIES * (PWR_MAX - PWR_INIT + 1);
    localparam logic [15:0] MAGIC    = 16'hBEAF;
    localparam logic [3:0]  TAG      = 4'hA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_layer = 1'b0;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_data = '0;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic [3:0]  chip_id;
    logic [3:0]  power_level;
    logic        sort_finish;
    logic        top_detect;

    always #5 clk = ~clk;

    layer_id_sorter dut (
        .clk         (clk),
        .rst         (rst),
        .f_layer     (f_layer),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .chip_id     (chip_id),
        .power_level (power_level),
        .sort_finish (sort_finish),
        .top_detect  (top_detect)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Log of transmit pulses since the last do_reset.
    logic [3:0] tx_pwr_q[$];
    int         tx_cyc_q[$];

    // Reference model state: phase 0 start, 1 listen, 2 negotiate, 3 answered, 4 top.
    int         m_phase;
    int         m_k;
    int         m_age;
    logic       e_txv;
    logic [31:0] e_txd;
    logic [3:0] e_id;
    logic [3:0] e_pwr;
    logic       e_fin;
    logic       e_top;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_frame(input int pwr, input int my, input int nxt);
        logic [3:0] p, m, n;
        p = 4'(pwr);
        m = 4'(my);
        n = 4'(nxt);
        return {TAG, p, m, n, MAGIC};
    endfunction

    // The k-th transmission uses power PWR_INIT + (k-1)/RETRIES.
    task automatic m_transmit();
        m_k++;
        e_pwr   = 4'(PWR_INIT + (m_k - 1) / RETRIES);
        e_txv   = 1'b1;
        e_txd   = mk_frame(int'(e_pwr), int'(e_id), int'(e_id) + 1);
        m_age   = 0;
        m_phase = 2;
    endtask

    task automatic model_step();
        logic       ok;
        logic [3:0] fmy, fnext;
        ok    = rx_valid && (rx_data[15:0] == MAGIC) && (rx_data[31:28] == TAG);
        fnext = rx_data[19:16];
        fmy   = rx_data[23:20];
        if (rst) begin
            m_phase = 0; m_k = 0; m_age = 0;
            e_txv = 1'b0; e_txd = '0; e_id = '0; e_pwr = 4'(PWR_INIT);
            e_fin = 1'b0; e_top = 1'b0;
        end else begin
            e_txv = 1'b0;
            case (m_phase)
                0: begin
                    if (f_layer) begin
                        e_id = '0;
                        m_transmit();
                    end else begin
                        m_phase = 1;
                    end
                end
                1: begin
                    if (ok) begin
                        e_id = fnext;
                        m_transmit();
                    end
                end
                2: begin
                    if (m_age == 0) begin
                        m_age = 1;
                    end else if (ok && (fmy == 4'(int'(e_id) + 1))) begin
                        m_phase = 3;
                        e_fin   = 1'b1;
                    end else if (m_age == TIMEOUT) begin
                        if (m_k == MAX_TX) begin
                            m_phase = 4;
                            e_fin   = 1'b1;
                            e_top   = 1'b1;
                        end else begin
                            m_transmit();
                        end
                    end else begin
                        m_age++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_eq("tx_valid", tx_valid, e_txv);
        check_eq("tx_data", tx_data, e_txd);
        check_eq("chip_id", chip_id, e_id);
        check_eq("power_level", power_level, e_pwr);
        check_eq("sort_finish", sort_finish, e_fin);
        check_eq("top_detect", top_detect, e_top);
        if (tx_valid) begin
            tx_pwr_q.push_back(tx_data[27:24]);
            tx_cyc_q.push_back(cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        rx_valid = v;
        rx_data  = d;
    endtask

    task automatic do_reset(input logic fl);
        rst     = 1'b1;
        f_layer = fl;
        drive(1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tx_pwr_q.delete();
        tx_cyc_q.delete();
    endtask

    task automatic run_until_fin(input int budget);
        int n;
        n = 0;
        while (!sort_finish && n < budget) begin
            tick();
            n++;
        end
        check_eq("fin_reached", sort_finish, 1);
    endtask

    initial begin
        int n;
        int exp_pwr[5];
        exp_pwr = '{1, 1, 2, 2, 3};

        // Reset state and bottom layer, immediate ack.
        do_reset(1'b1);
        check_eq("rst_txv", tx_valid, 0);
        check_eq("rst_txd", tx_data, 0);
        check_eq("rst_id", chip_id, 0);
        check_eq("rst_pwr", power_level, 1);
        check_eq("rst_fin", sort_finish, 0);
        check_eq("rst_top", top_detect, 0);
        tick();
        check_eq("bot_txv", tx_valid, 1);
        check_eq("bot_txd", tx_data, 32'hA101BEAF);
        drive(1'b1, 32'hA112BEAF);
        run_until_fin(5);
        check_eq("bot_top", top_detect, 0);

        // Middle layer learns its ID from below.
        do_reset(1'b0);
        tick();
        check_eq("mid_idle_txv", tx_valid, 0);
        drive(1'b1, 32'hA123BEAF);
        tick();
        check_eq("mid_id", chip_id, 3);
        check_eq("mid_txv", tx_valid, 1);
        check_eq("mid_txd", tx_data, 32'hA134BEAF);
        drive(1'b0, 32'h0);
        tick();
        drive(1'b1, 32'hA145BEAF);
        run_until_fin(20);
        check_eq("mid_top", top_detect, 0);

        // Retry then escalate.
        do_reset(1'b1);
        n = 0;
        while (tx_pwr_q.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        check_eq("esc_pulses", tx_pwr_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < tx_pwr_q.size()) check_eq("esc_pwr", tx_pwr_q[i], exp_pwr[i]);
            if (i > 0 && i < tx_cyc_q.size()) check_eq("esc_gap", tx_cyc_q[i] - tx_cyc_q[i-1], 16);
        end
        tick();
        tick();
        drive(1'b1, 32'hA112BEAF);
        run_until_fin(20);
        check_eq("esc_pwr_final", power_level, 3);
        check_eq("esc_top", top_detect, 0);

        // Top detection, then a late ack is ignored.
        do_reset(1'b1);
        n = 0;
        while (!top_detect && n < 700) begin
            tick();
            n++;
        end
        check_eq("top_flag", top_detect, 1);
        check_eq("top_fin", sort_finish, 1);
        check_eq("top_pulses", tx_pwr_q.size(), MAX_TX);
        if (tx_pwr_q.size() > 0) check_eq("top_last_pwr", tx_pwr_q[tx_pwr_q.size()-1], 15);
        drive(1'b1, 32'hA112BEAF);
        repeat (20) tick();
        check_eq("late_top", top_detect, 1);
        check_eq("late_pulses", tx_pwr_q.size(), MAX_TX);
        check_eq("late_pwr", power_level, 15);

        // Ack sampled on the last window cycle wins over the retry.
        do_reset(1'b1);
        tick();
        tick();
        repeat (14) tick();
        drive(1'b1, 32'hA112BEAF);
        tick();
        check_eq("edge_fin", sort_finish, 1);
        check_eq("edge_txv", tx_valid, 0);
        check_eq("edge_pulses", tx_pwr_q.size(), 1);

        // Corrupted or mismatched frames are ignored; the window times out and retries.
        do_reset(1'b1);
        tick();
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: drive(1'b1, 32'hA112BEEF);
                1: drive(1'b1, 32'hB112BEAF);
                2: drive(1'b1, 32'hA122BEAF);
                default: drive(1'b0, 32'hA112BEAF);
            endcase
            tick();
        end
        check_eq("filt_retry_txv", tx_valid, 1);
        check_eq("filt_pulses", tx_pwr_q.size(), 2);
        check_eq("filt_fin", sort_finish, 0);

        // chip_id 15 hands out 0 to the layer above.
        do_reset(1'b0);
        tick();
        drive(1'b1, 32'hA10FBEAF);
        tick();
        check_eq("wrap_id", chip_id, 15);
        check_eq("wrap_txd", tx_data, 32'hA1F0BEAF);
        drive(1'b1, 32'hA101BEAF);
        run_until_fin(20);
        check_eq("wrap_top", top_detect, 0);

        // Reset in the middle of a window at power 4.
        do_reset(1'b1);
        n = 0;
        while (!(power_level == 4 && !tx_valid) && n < 300) begin
            tick();
            n++;
        end
        check_eq("mid_rst_pwr4", power_level, 4);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_eq("mrst_txv", tx_valid, 0);
        check_eq("mrst_txd", tx_data, 0);
        check_eq("mrst_id", chip_id, 0);
        check_eq("mrst_pwr", power_level, 1);
        check_eq("mrst_fin", sort_finish, 0);
        check_eq("mrst_top", top_detect, 0);
        rst = 1'b0;
        tick();
        check_eq("restart_txv", tx_valid, 1);
        check_eq("restart_txd", tx_data, 32'hA101BEAF);

        // Randomized traffic.
        for (int s = 0; s < 12; s++) begin
            int ack_pct;
            int fin_run;
            case ($urandom_range(0, 3))
                0: ack_pct = 0;
                1: ack_pct = 2;
                2: ack_pct = 10;
                default: ack_pct = 30;
            endcase
            do_reset(1'($urandom_range(0, 1)));
            fin_run = 0;
            for (int c = 0; c < 700 && fin_run < 20; c++) begin
                int r;
                int idx;
                logic [31:0] d;
                r = $urandom_range(0, 99);
                if (r < ack_pct) begin
                    drive(1'b1, mk_frame($urandom_range(0, 15), int'(e_id) + 1, $urandom_range(0, 15)));
                end else if (r < ack_pct + 15) begin
                    drive(1'b1, mk_frame($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)));
                end else if (r < ack_pct + 25) begin
                    d = mk_frame($urandom_range(0, 15), int'(e_id) + 1, $urandom_range(0, 15));
                    if ($urandom_range(0, 1) == 1) idx = $urandom_range(0, 15);
                    else idx = 28 + $urandom_range(0, 3);
                    d[idx] = ~d[idx];
                    drive(1'b1, d);
                end else begin
                    drive(1'b0, $urandom);
                end
                if ($urandom_range(0, 399) == 0) rst = 1'b1;
                tick();
                rst = 1'b0;
                if (sort_finish) fin_run++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
